// File: rtl/pixel_pair_if.sv
// Pixel-pair stream in, assembled frame out, for the content-loss front end.
// The loader sits on the slave side; the upstream source and loss consumer sit on the master side.
interface pixel_pair_if #(
   parameter int NUM_PIXELS = 1024,
   parameter int PIXEL_W    = 16
);
   localparam int CNT_W = $clog2(NUM_PIXELS) + 1;

   logic                          in_valid;
   logic                          in_ready;
   logic [PIXEL_W-1:0]            in_content;
   logic [PIXEL_W-1:0]            in_generated;
   logic                          in_last;
   logic                          frame_abort;
   logic                          frame_ack;
   logic                          frame_valid;
   logic [NUM_PIXELS*PIXEL_W-1:0] content_pixels;
   logic [NUM_PIXELS*PIXEL_W-1:0] generated_pixels;
   logic [CNT_W-1:0]              pixel_count;
   logic [15:0]                   frame_count;
   logic                          err_short;
   logic                          err_long;

   modport slave (
      input  in_valid, in_content, in_generated, in_last, frame_abort, frame_ack,
      output in_ready, frame_valid, content_pixels, generated_pixels,
             pixel_count, frame_count, err_short, err_long
   );

   modport master (
      output in_valid, in_content, in_generated, in_last, frame_abort, frame_ack,
      input  in_ready, frame_valid, content_pixels, generated_pixels,
             pixel_count, frame_count, err_short, err_long
   );
endinterface

// File: rtl/pixel_pair_loader.sv
// Assembles NUM_PIXELS (content, generated) pairs into two registered banks and
// holds the completed frame until the consumer acks it; flags short/long frames.
module pixel_pair_loader #(
   parameter int NUM_PIXELS = 1024,
   parameter int PIXEL_W    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   pixel_pair_if.slave    bus
);
   localparam int IDX_W = $clog2(NUM_PIXELS);
   localparam int CNT_W = IDX_W + 1;

   typedef enum logic {FILL, HOLD} state_t;

   state_t                             state_q, state_d;
   logic [NUM_PIXELS-1:0][PIXEL_W-1:0] content_q, generated_q;
   logic [CNT_W-1:0]                   pix_cnt_q;
   logic [15:0]                        frm_cnt_q;
   logic                               err_short_q, err_long_q;
   logic                               wr, last_slot;

   // Abort is folded in here because in_ready is still high in the abort cycle.
   assign wr        = bus.in_valid && (state_q == FILL) && !bus.frame_abort;
   assign last_slot = (pix_cnt_q == CNT_W'(NUM_PIXELS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL: if (wr && last_slot) state_d = HOLD;
         HOLD: if (bus.frame_ack)   state_d = FILL;
         default:                   state_d = FILL;
      endcase
      if (bus.frame_abort) state_d = FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q   <= '0;
         frm_cnt_q   <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         err_short_q <= wr && bus.in_last && !last_slot;
         err_long_q  <= wr && last_slot && !bus.in_last;
         if (bus.frame_abort) begin
            pix_cnt_q <= '0;
         end else if (wr) begin
            if (last_slot) begin
               pix_cnt_q <= CNT_W'(NUM_PIXELS);
               frm_cnt_q <= frm_cnt_q + 16'd1;
            end else if (bus.in_last) begin
               pix_cnt_q <= '0;
            end else begin
               pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            end
         end else if (state_q == HOLD && bus.frame_ack) begin
            pix_cnt_q <= '0;
         end
      end
   end

   // In FILL the count never exceeds NUM_PIXELS-1, so the low bits are a valid index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         content_q   <= '0;
         generated_q <= '0;
      end else if (wr) begin
         content_q[pix_cnt_q[IDX_W-1:0]]   <= bus.in_content;
         generated_q[pix_cnt_q[IDX_W-1:0]] <= bus.in_generated;
      end
   end

   assign bus.in_ready         = (state_q == FILL);
   assign bus.frame_valid      = (state_q == HOLD);
   assign bus.content_pixels   = content_q;
   assign bus.generated_pixels = generated_q;
   assign bus.pixel_count      = pix_cnt_q;
   assign bus.frame_count      = frm_cnt_q;
   assign bus.err_short        = err_short_q;
   assign bus.err_long         = err_long_q;
endmodule

// File: tb/tb_pixel_pair_loader.sv
// Randomized bench for pixel_pair_loader against a frame-level reference model.
module tb_pixel_pair_loader;
   localparam int N = 1024;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pixel_pair_if #(.NUM_PIXELS(N), .PIXEL_W(W)) bus ();
   pixel_pair_loader #(.NUM_PIXELS(N), .PIXEL_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [W-1:0] m_c [N];
   logic [W-1:0] m_g [N];
   int           m_cnt;
   int           m_fc;
   bit           m_hold;
   bit           m_es, m_el;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_c[i] = '0; m_g[i] = '0; end
      m_cnt = 0; m_fc = 0; m_hold = 0; m_es = 0; m_el = 0;
   endtask

   function automatic int bank_diff();
      int d = 0;
      for (int i = 0; i < N; i++) begin
         if (bus.content_pixels[i*W +: W]   !== m_c[i]) d++;
         if (bus.generated_pixels[i*W +: W] !== m_g[i]) d++;
      end
      return d;
   endfunction

   task automatic check_outputs();
      chk("in_ready",    bus.in_ready,    !m_hold);
      chk("frame_valid", bus.frame_valid, m_hold);
      chk("pixel_count", bus.pixel_count, m_cnt);
      chk("frame_count", bus.frame_count, m_fc);
      chk("err_short",   bus.err_short,   m_es);
      chk("err_long",    bus.err_long,    m_el);
   endtask

   // One clock: drive inputs, advance the model with the same inputs, check after the edge.
   task automatic cyc(input bit v, input logic [W-1:0] c, input logic [W-1:0] g,
                      input bit l, input bit ab, input bit ak);
      bit acc;
      bus.in_valid = v; bus.in_content = c; bus.in_generated = g;
      bus.in_last = l; bus.frame_abort = ab; bus.frame_ack = ak;
      @(posedge clk);
      acc = v && !m_hold && !ab;
      m_es = 0; m_el = 0;
      if (ab) begin
         m_hold = 0; m_cnt = 0;
      end else if (acc) begin
         m_c[m_cnt] = c; m_g[m_cnt] = g;
         if (m_cnt == N - 1) begin
            m_el = !l; m_hold = 1; m_cnt = N; m_fc = (m_fc + 1) % 65536;
         end else if (l) begin
            m_es = 1; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (m_hold && ak) begin
         m_hold = 0; m_cnt = 0;
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input bit ab, input bit ak);
      cyc(1'b0, W'($urandom), W'($urandom), 1'b0, ab, ak);
   endtask

   // Random frame of `len` pairs with random stalls; in_last on pair last_at (or none if <0).
   task automatic rand_frame(input int len, input int last_at);
      int sent = 0;
      while (sent < len) begin
         if ($urandom_range(3) == 0) idle(1'b0, 1'b0);
         else begin
            cyc(1'b1, W'($urandom), W'($urandom), sent == last_at, 1'b0, 1'b0);
            sent++;
         end
      end
   endtask

   initial begin
      bus.in_valid = 0; bus.in_content = '0; bus.in_generated = '0;
      bus.in_last = 0; bus.frame_abort = 0; bus.frame_ack = 0;
      model_reset();
      #12;
      check_outputs();
      chk("reset_bank", bank_diff(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // full back-to-back frame
      for (int i = 0; i < N; i++)
         cyc(1'b1, W'(i), W'(i + 3), i == N - 1, 1'b0, 1'b0);
      chk("full_c5",    bus.content_pixels[5*W +: W], 16'd5);
      chk("full_g1023", bus.generated_pixels[1023*W +: W], 16'd1026);
      chk("full_fv",    bus.frame_valid, 1'b1);
      chk("full_bank",  bank_diff(), 0);

      // backpressure while holding
      for (int i = 0; i < 20; i++)
         cyc(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_bank", bank_diff(), 0);
      idle(1'b0, 1'b1);
      chk("ack_ready", bus.in_ready, 1'b1);
      chk("ack_count", bus.pixel_count, 0);

      // early last on pair 10, then a clean frame
      rand_frame(11, 10);
      idle(1'b0, 1'b0);
      rand_frame(N, N - 1);
      chk("clean_bank", bank_diff(), 0);
      idle(1'b0, 1'b1);

      // missing last
      rand_frame(N, -1);
      chk("long_bank", bank_diff(), 0);
      idle(1'b0, 1'b1);

      // abort alongside an accepted pair at pixel_count = 500
      rand_frame(500, -1);
      cyc(1'b1, 16'hBEEF, 16'hCAFE, 1'b0, 1'b1, 1'b0);
      chk("abort_c500", bus.content_pixels[500*W +: W], m_c[500]);
      chk("abort_bank", bank_diff(), 0);
      rand_frame(N, N - 1);
      idle(1'b1, 1'b1);  // abort with ack in HOLD

      // random traffic with rare last/abort/ack
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(3) != 0), W'($urandom), W'($urandom),
             1'($urandom_range(200) == 0), 1'($urandom_range(150) == 0),
             1'($urandom_range(3) == 0));
      chk("rand_bank", bank_diff(), 0);

      // async reset mid-frame
      idle(1'b1, 1'b0);
      rand_frame(300, -1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("areset_bank", bank_diff(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      rand_frame(N, N - 1);
      chk("post_reset_bank", bank_diff(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pixel_pair_loader.md
# pixel_pair_loader

Upstream stage of the content-loss path. Accepts a serial stream of (content, generated) pixel pairs over a valid/ready handshake, assembles one full frame of NUM_PIXELS pairs into two parallel registered banks, and presents them as flat vectors to the content-loss stage. It holds each completed frame stable until the consumer acknowledges it, and flags malformed frames.

## Interface
- NUM_PIXELS, 1024, pixels per frame (power of two, ≥ 2)
- PIXEL_W, 16, bits per pixel
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input pair valid
- in_ready  out  1  loader can accept a pair
- in_content  in  PIXEL_W  content pixel of current pair
- in_generated  in  PIXEL_W  generated pixel of current pair
- in_last  in  1  marks final pair of a frame
- frame_abort  in  1  discard the partial or held frame
- frame_ack  in  1  consumer has taken the held frame
- frame_valid  out  1  banks hold a complete frame
- content_pixels  out  NUM_PIXELS*PIXEL_W  content bank; pixel i at bits [i*PIXEL_W +: PIXEL_W]
- generated_pixels  out  NUM_PIXELS*PIXEL_W  generated bank, same packing
- pixel_count  out  log2(NUM_PIXELS)+1  pairs accepted in current frame
- frame_count  out  16  completed frames, wraps at 2^16
- err_short  out  1  one-cycle pulse: in_last before the NUM_PIXELS-th pair
- err_long  out  1  one-cycle pulse: NUM_PIXELS-th pair arrived without in_last

## Operation
- Two states: FILL, HOLD. Reset state FILL.
- Accept = in_valid && in_ready. in_ready = (state == FILL), decoded from the state register only. It has no combinational path from any input.
- FILL, accept: write in_content and in_generated to bank index pixel_count, then increment pixel_count.
  - Accepted pair is pair NUM_PIXELS: go to HOLD, set pixel_count to NUM_PIXELS, increment frame_count.
  - If in_last is low on that pair, pulse err_long. The frame is still delivered.
  - in_last high on an earlier pair: pulse err_short, reset pixel_count to 0, stay in FILL. The frame is discarded and frame_count is unchanged. Bank contents are not cleared; they are overwritten by the next frame.
- HOLD: frame_valid = 1, in_ready = 0. Banks do not change. frame_ack causes return to FILL with pixel_count = 0.
- frame_abort, in any state: next state FILL, pixel_count = 0.
  - A pair offered in that cycle is not written and no error pulses are raised. Do not depend on in_ready for this, because in_ready is already high in that cycle.
  - Priority: abort over ack, abort over acceptance.
- frame_ack outside HOLD is ignored.
- Arithmetic:
  - pixel_count is unsigned, range 0..NUM_PIXELS, and never wraps.
  - frame_count wraps modulo 2^16.
  - Pixel data is stored verbatim, with no sign or width conversion.

## Timing
- Reset values of outputs:
  - in_ready = 1
  - frame_valid = 0
  - all bank bits = 0
  - pixel_count = 0
  - frame_count = 0
  - err_short = 0, err_long = 0
- Bank write latency: a pair accepted at edge k is visible on the output vectors after edge k.
- Final pair accepted at edge k: frame_valid = 1 and in_ready = 0 from edge k onward.
- frame_ack sampled high at edge m while in HOLD: frame_valid = 0 and in_ready = 1 after edge m. The earliest next accept is edge m+1.
- Throughput: one pair per cycle during FILL. A full frame takes at least NUM_PIXELS+1 cycles including one ack cycle.
- err_short and err_long are registered. Each is high for exactly the one cycle following the offending accept edge.
- in_valid low inside a frame stalls it indefinitely, with no timeout.
- rst_n asserted mid-frame or in HOLD: all state and outputs go to reset values immediately, without waiting for clk.

## Test plan
- Full frame: 1024 back-to-back pairs with content = i and generated = i+3, in_last on i = 1023 -> frame_valid after edge 1024, content word 5 = 5, generated word 1023 = 1026, frame_count = 1, no errors.
- Backpressure: after the full frame, hold in_valid = 1 and keep frame_ack low for 20 cycles -> in_ready stays 0 and banks are unchanged; assert frame_ack -> in_ready = 1 on the next cycle and pixel_count = 0.
- Early last: in_last on pair 10 -> one err_short pulse, pixel_count = 0, frame_count unchanged, frame_valid stays 0; the following clean 1024-pair frame completes normally.
- Missing last: 1024 pairs with in_last never set -> one err_long pulse, frame_valid = 1, frame_count increments.
- Abort vs. accept: assert frame_abort together with a valid pair at pixel_count = 500 -> pixel_count = 0, that pair is not written, no error pulses; assert abort together with ack in HOLD -> FILL, pixel_count = 0.
- Async reset: drop rst_n between edges at pixel_count = 300 -> outputs reach reset values before the next edge; frame_count = 0.
